// File: rtl/snake_pkg.sv
// Shared types and IR key constants for the snake game controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package snake_pkg;

    // Display source selected by the controller
    typedef enum logic [1:0] {
        SCR_START = 2'd0,
        SCR_GAME  = 2'd1,
        SCR_PAUSE = 2'd2,
        SCR_END   = 2'd3
    } screen_t;

    // Snake heading
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Controller states; one per display screen
    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    // Default NEC command words of the remote in use
    localparam logic [31:0] KEY_OK_DFLT     = 32'h20DF22DD;
    localparam logic [31:0] KEY_PAUSE_DFLT  = 32'h20DF55AA;
    localparam logic [31:0] KEY_UP_DFLT     = 32'h20DF02FD;
    localparam logic [31:0] KEY_DOWN_DFLT   = 32'h20DF827D;
    localparam logic [31:0] KEY_LEFT_DFLT   = 32'h20DFE01F;
    localparam logic [31:0] KEY_RIGHT_DFLT  = 32'h20DF609F;
    localparam logic [31:0] KEY_REPEAT_DFLT = 32'hFFFFFFFF;

    // 180-degree reversal of a heading
    function automatic dir_t dir_opposite(input dir_t d);
        dir_t r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            default:   r = DIR_LEFT;
        endcase
        return r;
    endfunction

    // Screen shown for each controller state
    function automatic screen_t screen_of(input state_t s);
        screen_t r;
        case (s)
            S_START: r = SCR_START;
            S_PLAY:  r = SCR_GAME;
            S_PAUSE: r = SCR_PAUSE;
            default: r = SCR_END;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Step-rate counter: counts 0..PERIOD-1 while enabled and not held.
// Latency: tick is combinational from the count register (asserted while count==PERIOD-1).
// Backpressure: none; hold freezes the count, clear zeroes it.
module tick_gen #(
    parameter int PERIOD = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic hold,
    input  logic clear,
    output logic tick
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap = (cnt == W'(PERIOD - 1));
    assign tick = en && !hold && wrap;

    // Count while running; clear has priority over counting, hold freezes
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !hold) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Snake game controller: IR key handling, game FSM, step timing, direction commit, frame requests.
// Latency: every output is registered; a key or tick acts on the edge it is sampled, visible the next cycle.
// Backpressure: none on inputs; frame_req is held until frame_ack, with new events coalesced.
module game_ctrl
    import snake_pkg::*;
#(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          TICK_HZ    = 4,
    parameter logic [31:0] KEY_OK     = KEY_OK_DFLT,
    parameter logic [31:0] KEY_PAUSE  = KEY_PAUSE_DFLT,
    parameter logic [31:0] KEY_UP     = KEY_UP_DFLT,
    parameter logic [31:0] KEY_DOWN   = KEY_DOWN_DFLT,
    parameter logic [31:0] KEY_LEFT   = KEY_LEFT_DFLT,
    parameter logic [31:0] KEY_RIGHT  = KEY_RIGHT_DFLT,
    parameter logic [31:0] KEY_REPEAT = KEY_REPEAT_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_valid,
    input  logic [31:0] ir_word,
    input  logic        game_over,
    input  logic        frame_ack,
    output screen_t     screen_sel,
    output dir_t        dir,
    output logic        game_step,
    output logic        game_rst,
    output logic        frame_req
);

    localparam int TICK_PERIOD = CLK_HZ / TICK_HZ;

    state_t state;
    state_t state_nxt;

    // Pending direction: latest accepted key since the last step
    logic   pend_vld;
    dir_t   pend_dir;
    logic   pend_vld_nxt;
    dir_t   pend_dir_nxt;

    // Decoded keys (repeat codes never count as a key)
    logic   key_vld;
    logic   key_ok;
    logic   key_pause;
    logic   key_dir_vld;
    dir_t   key_dir;

    logic   start_go;
    logic   dir_acc;
    logic   tick;
    logic   step_fire;
    logic   tick_en;
    logic   tick_hold;

    // Decode the incoming IR word into one-hot key events
    always_comb begin
        key_vld     = ir_valid && (ir_word != KEY_REPEAT);
        key_ok      = key_vld && (ir_word == KEY_OK);
        key_pause   = key_vld && (ir_word == KEY_PAUSE);
        key_dir_vld = 1'b0;
        key_dir     = DIR_UP;
        if (key_vld) begin
            if (ir_word == KEY_UP) begin
                key_dir_vld = 1'b1;
                key_dir     = DIR_UP;
            end else if (ir_word == KEY_DOWN) begin
                key_dir_vld = 1'b1;
                key_dir     = DIR_DOWN;
            end else if (ir_word == KEY_LEFT) begin
                key_dir_vld = 1'b1;
                key_dir     = DIR_LEFT;
            end else if (ir_word == KEY_RIGHT) begin
                key_dir_vld = 1'b1;
                key_dir     = DIR_RIGHT;
            end
        end
    end

    // Next-state selection; a collision outranks a pause key in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_START: if (key_ok)     state_nxt = S_PLAY;
            S_PLAY: begin
                if (game_over)       state_nxt = S_OVER;
                else if (key_pause)  state_nxt = S_PAUSE;
            end
            S_PAUSE: if (key_pause)  state_nxt = S_PLAY;
            default: if (key_ok)     state_nxt = S_START;
        endcase
    end

    // Key is evaluated before step gating, so a key landing on a tick commits at that tick.
    // Reversal is judged against the committed heading, never the pending one.
    always_comb begin
        start_go     = (state == S_START) && key_ok;
        dir_acc      = (state == S_PLAY) && key_dir_vld && (key_dir != dir_opposite(dir));
        pend_vld_nxt = pend_vld || dir_acc;
        pend_dir_nxt = dir_acc ? key_dir : pend_dir;
        step_fire    = tick && !game_over;
        tick_en      = (state == S_PLAY) || (state == S_PAUSE);
        tick_hold    = (state == S_PAUSE);
    end

    tick_gen #(
        .PERIOD (TICK_PERIOD)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .hold  (tick_hold),
        .clear (start_go),
        .tick  (tick)
    );

    // Game FSM with registered screen, direction, strobes and frame request
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_START;
            screen_sel <= SCR_START;
            dir        <= DIR_RIGHT;
            pend_vld   <= 1'b0;
            pend_dir   <= DIR_RIGHT;
            game_step  <= 1'b0;
            game_rst   <= 1'b0;
            frame_req  <= 1'b1;
        end else begin
            state      <= state_nxt;
            screen_sel <= screen_of(state_nxt);
            game_rst   <= start_go;
            game_step  <= step_fire;

            if (start_go) begin
                dir      <= DIR_RIGHT;
                pend_vld <= 1'b0;
                pend_dir <= DIR_RIGHT;
            end else if (step_fire) begin
                if (pend_vld_nxt) begin
                    dir <= pend_dir_nxt;
                end
                pend_vld <= 1'b0;
            end else begin
                pend_vld <= pend_vld_nxt;
                pend_dir <= pend_dir_nxt;
            end

            // A new event wins over a coincident acknowledge
            if ((state_nxt != state) || step_fire) begin
                frame_req <= 1'b1;
            end else if (frame_ack) begin
                frame_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a 10-cycle step period.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: frame_ack driven explicitly by the stimulus.
module tb_game_ctrl;

    localparam logic [31:0] K_OK     = 32'h20DF22DD;
    localparam logic [31:0] K_PAUSE  = 32'h20DF55AA;
    localparam logic [31:0] K_UP     = 32'h20DF02FD;
    localparam logic [31:0] K_DOWN   = 32'h20DF827D;
    localparam logic [31:0] K_LEFT   = 32'h20DFE01F;
    localparam logic [31:0] K_RIGHT  = 32'h20DF609F;
    localparam logic [31:0] K_REPEAT = 32'hFFFFFFFF;

    localparam int SEL_START = 0;
    localparam int SEL_GAME  = 1;
    localparam int SEL_PAUSE = 2;
    localparam int SEL_END   = 3;
    localparam int D_UP      = 0;
    localparam int D_RIGHT   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ir_valid;
    logic [31:0] ir_word;
    logic        game_over;
    logic        frame_ack;
    logic [1:0]  screen_sel;
    logic [1:0]  dir;
    logic        game_step;
    logic        game_rst;
    logic        frame_req;

    int checks   = 0;
    int failures = 0;
    int n;
    int paused_steps;

    always #5 clk = ~clk;

    game_ctrl #(
        .CLK_HZ  (20),
        .TICK_HZ (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ir_valid   (ir_valid),
        .ir_word    (ir_word),
        .game_over  (game_over),
        .frame_ack  (frame_ack),
        .screen_sel (screen_sel),
        .dir        (dir),
        .game_step  (game_step),
        .game_rst   (game_rst),
        .frame_req  (frame_req)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a key for one edge; returns on the falling edge after it was sampled
    task automatic send_key(input logic [31:0] w);
        ir_valid = 1'b1;
        ir_word  = w;
        @(negedge clk);
        ir_valid = 1'b0;
        ir_word  = '0;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    // Falling edges until the next game_step, bounded by max
    task automatic wait_step(input int max, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!game_step && cnt < max);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        ir_valid  = 1'b0;
        ir_word   = '0;
        game_over = 1'b0;
        frame_ack = 1'b0;
        idle(3);

        // Reset state
        chk("rst_screen", 32'(screen_sel), SEL_START);
        chk("rst_dir",    32'(dir),        D_RIGHT);
        chk("rst_step",   32'(game_step),  0);
        chk("rst_grst",   32'(game_rst),   0);
        chk("rst_freq",   32'(frame_req),  1);

        reset = 1'b0;
        idle(1);
        frame_ack = 1'b1;
        idle(1);
        frame_ack = 1'b0;
        chk("ack_clear", 32'(frame_req), 0);

        // Repeat and unknown words are ignored in START
        send_key(K_REPEAT);
        chk("rep_screen", 32'(screen_sel), SEL_START);
        send_key(32'h12345678);
        chk("unk_screen", 32'(screen_sel), SEL_START);
        chk("unk_grst",   32'(game_rst),   0);

        // Start game: reset pulse, GAME screen, 10-cycle step period
        send_key(K_OK);
        chk("go_grst",   32'(game_rst),   1);
        chk("go_screen", 32'(screen_sel), SEL_GAME);
        chk("go_dir",    32'(dir),        D_RIGHT);
        chk("go_freq",   32'(frame_req),  1);
        idle(1);
        chk("go_grst_once", 32'(game_rst), 0);
        wait_step(50, n);
        chk("first_step", 32'(n), 9);
        wait_step(50, n);
        chk("step_period", 32'(n), 10);

        // LEFT reverses RIGHT and is dropped; UP commits at the next step only
        send_key(K_LEFT);
        send_key(K_UP);
        chk("dir_before_step", 32'(dir), D_RIGHT);
        wait_step(50, n);
        chk("dir_step_gap", 32'(n), 8);
        chk("dir_up", 32'(dir), D_UP);
        idle(3);
        chk("dir_between", 32'(dir), D_UP);
        wait_step(50, n);
        chk("step_period2", 32'(n), 7);

        // Reversal judged against committed UP: RIGHT pending, DOWN dropped
        send_key(K_RIGHT);
        send_key(K_DOWN);
        wait_step(50, n);
        chk("rev_gap", 32'(n), 8);
        chk("rev_committed", 32'(dir), D_RIGHT);

        // Pause at count 4, hold 50 cycles, resume: step 6 cycles later
        idle(3);
        send_key(K_PAUSE);
        chk("pause_screen", 32'(screen_sel), SEL_PAUSE);
        paused_steps = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (game_step) paused_steps++;
        end
        chk("paused_steps", 32'(paused_steps), 0);
        send_key(K_PAUSE);
        chk("resume_screen", 32'(screen_sel), SEL_GAME);
        wait_step(50, n);
        chk("resume_step", 32'(n), 6);

        // Collision coinciding with a tick suppresses the step
        idle(9);
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        chk("over_nostep", 32'(game_step),  0);
        chk("over_screen", 32'(screen_sel), SEL_END);
        send_key(K_UP);
        chk("over_key_screen", 32'(screen_sel), SEL_END);
        chk("over_key_dir",    32'(dir),        D_RIGHT);
        send_key(K_OK);
        chk("over_ok", 32'(screen_sel), SEL_START);

        // Frame request held across steps, coalesced with a step-cycle ack
        send_key(K_OK);
        wait_step(50, n);
        chk("fr_first_step", 32'(n), 10);
        wait_step(50, n);
        chk("fr_held", 32'(frame_req), 1);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("fr_ack", 32'(frame_req), 0);
        idle(8);
        frame_ack = 1'b1;
        @(negedge clk);
        chk("fr_ack_step", 32'(game_step), 1);
        chk("fr_coalesce", 32'(frame_req), 1);
        @(negedge clk);
        frame_ack = 1'b0;
        chk("fr_ack_after", 32'(frame_req), 0);

        // Reset during pause overrides a coincident OK key and ack
        send_key(K_UP);
        wait_step(50, n);
        chk("pre_rst_dir", 32'(dir), D_UP);
        send_key(K_PAUSE);
        chk("pre_rst_screen", 32'(screen_sel), SEL_PAUSE);
        reset     = 1'b1;
        ir_valid  = 1'b1;
        ir_word   = K_OK;
        frame_ack = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        ir_valid  = 1'b0;
        ir_word   = '0;
        frame_ack = 1'b0;
        chk("mid_rst_screen", 32'(screen_sel), SEL_START);
        chk("mid_rst_dir",    32'(dir),        D_RIGHT);
        chk("mid_rst_step",   32'(game_step),  0);
        chk("mid_rst_grst",   32'(game_rst),   0);
        chk("mid_rst_freq",   32'(frame_req),  1);
        send_key(K_OK);
        wait_step(50, n);
        chk("post_rst_step", 32'(n), 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
